mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/arb_pick.sv | 27 ++
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Types and constants that the two-port RAM arbiter and its winner-select
//   sub-module share.
//   Contents:
//     ADDR_W_DEF / DATA_W_DEF : default RAM word-address and data widths
//     NUM_REQ                 : number of requesters (fixed at 2)
//     arb_state_e             : arbiter FSM states IDLE, ACCESS, RESP
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 32;
    localparam int NUM_REQ    = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/arb_pick.sv
// arb_pick
//   Purely combinational winner selection for the two-requester arbiter.
//   Ports:
//     req  in  NUM_REQ : request bits, bit i belongs to requester i
//     last in  1       : index of the requester served last
//     gnt  out NUM_REQ : one-hot winner, all zero when req == 0
//   A lone requester always wins. On a tie the requester that was not served
//   last wins. Feeding last = 1 constantly gives fixed priority to requester 0.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               last,
    output logic [NUM_REQ-1:0] gnt
);

    always_comb begin
        gnt = '0;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = '0;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one synchronous single-port RAM between two requesters. Each access
//   walks IDLE -> ACCESS -> RESP -> IDLE, so done arrives 3 cycles after the
//   request is sampled and the RAM serves at most one access per 3 cycles.
//   Configuration macro:
//     MEM_ARB_ROUND_ROBIN_EN : defined   -> ties go to the requester not served
//                                           last (last-served pointer kept)
//                              undefined -> requester 0 always wins ties, no
//                                           pointer register
//   Ports:
//     CLK, RST         : clock (rising edge), synchronous active-high reset
//     req, we          : per-requester request and write enable (1 = write)
//     addr0/1, wdata0/1: per-requester word address and write data
//     gnt              : one-hot grant, held from ACCESS through RESP
//     done             : one-cycle completion pulse for the winner
//     rdata            : read data (0 after a write), valid while done is high
//     ram_*            : RAM chip select, direction (1 = read), address, data
//     ram_rdata        : RAM read data, valid the cycle after the read edge
//     dbg_state        : current FSM state
//   Handshake: a requester raises req and keeps its we/addr/wdata stable until
//   the cycle after it is sampled in IDLE; from then the access is committed
//   and req is ignored until the FSM returns to IDLE. A req still high in the
//   done cycle is sampled as a fresh request.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [1:0]         req,
    input  logic [1:0]         we,
    input  logic [ADDR_W-1:0]  addr0,
    input  logic [ADDR_W-1:0]  addr1,
    input  logic [DATA_W-1:0]  wdata0,
    input  logic [DATA_W-1:0]  wdata1,
    output logic [1:0]         gnt,
    output logic [1:0]         done,
    output logic [DATA_W-1:0]  rdata,
    output logic               ram_cs,
    output logic               ram_r_w,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic [DATA_W-1:0]  ram_wdata,
    input  logic [DATA_W-1:0]  ram_rdata,
    output arb_state_e         dbg_state
);

    arb_state_e          state_q, state_d;
    logic [1:0]          gnt_q, gnt_d;
    logic [1:0]          done_q, done_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [1:0]          pick_gnt;
    logic                last_w;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_q, last_d;
    assign last_w = last_q;
`else
    // Pretending requester 1 was always served last gives requester 0 every tie.
    assign last_w = 1'b1;
`endif

    arb_pick u_pick (
        .req  (req),
        .last (last_w),
        .gnt  (pick_gnt)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        rdata_d = rdata_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    state_d = ACCESS;
                    gnt_d   = pick_gnt;
                    we_d    = pick_gnt[1] ? we[1]  : we[0];
                    addr_d  = pick_gnt[1] ? addr1  : addr0;
                    wdata_d = pick_gnt[1] ? wdata1 : wdata0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_d  = pick_gnt[1];
`endif
                end
            end
            ACCESS: begin
                state_d = RESP;
            end
            RESP: begin
                // RAM read data is valid now, one cycle after the ACCESS edge.
                state_d = IDLE;
                done_d  = gnt_q;
                gnt_d   = '0;
                rdata_d = we_q ? '0 : ram_rdata;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q  <= last_d;
`endif
        end
    end

    // RAM pins are idle (deselected, read direction, zero bus) outside ACCESS,
    // so reset drops them immediately without extra flops.
    always_comb begin
        ram_cs    = (state_q == ACCESS);
        ram_r_w   = (state_q == ACCESS) ? ~we_q   : 1'b1;
        ram_addr  = (state_q == ACCESS) ? addr_q  : '0;
        ram_wdata = (state_q == ACCESS) ? wdata_q : '0;
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign dbg_state = state_q;

endmodule
